// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a single-cycle data RAM.
// Optional misaligned-access trap is compiled in with `define MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_datain_o,
  output logic        ram_write_o,
  output logic        ram_read_o,
  input  logic [31:0] ram_dataout_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [2:0]  state_q,    state_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [1:0]  size_q,     size_d;
  logic        we_q,       we_d;
  logic        sx_q,       sx_d;
  logic [31:0] rdata_q,    rdata_d;
  logic [31:0] merge_q,    merge_d;
  logic        misalign_q, misalign_d;
  logic        trap_req;

  // Select the addressed lane of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{sx & b[7]}}, b};
      2'b01:   res = {{16{sx & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/half of the old RAM word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      case (off)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) res[31:16] = wd[15:0];
      else        res[15:0]  = wd[15:0];
    end else begin
      res = wd;
    end
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign trap_req = is_misaligned(size_i, addr_i[1:0]);
`else
  assign trap_req = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    we_d       = we_q;
    sx_d       = sx_q;
    rdata_d    = rdata_q;
    merge_d    = merge_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          size_d     = size_i;
          we_d       = we_i;
          sx_d       = sign_ext_i;
          misalign_d = trap_req;
          if (trap_req) begin
            state_d = S_DONE;
          end else if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (!we_q) begin
          rdata_d = load_extend(ram_dataout_i, size_q, addr_q[1:0], sx_q);
          state_d = S_DONE;
        end else if (size_q[1]) begin
          state_d = S_DONE;
        end else begin
          merge_d = ram_dataout_i;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      we_q       <= 1'b0;
      sx_q       <= 1'b0;
      rdata_q    <= 32'd0;
      merge_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      we_q       <= we_d;
      sx_q       <= sx_d;
      rdata_q    <= rdata_d;
      merge_q    <= merge_d;
      misalign_q <= misalign_d;
    end
  end

  // RAM strobes are gated by reset directly so an aborted access never commits.
  assign ram_read_o   = (state_q == S_ACCESS) && !rst_i;
  assign ram_write_o  = (((state_q == S_ACCESS) && we_q && size_q[1]) ||
                         (state_q == S_WRITE)) && !rst_i;
  assign ram_datain_o = (state_q == S_WRITE) ? merge_lane(merge_q, wdata_q, size_q, addr_q[1:0])
                                             : wdata_q;
  assign ram_addr_o   = {addr_q[31:2], 2'b00};
  assign busy_o       = (state_q == S_WAIT) || (state_q == S_ACCESS) || (state_q == S_WRITE);
  assign done_o       = (state_q == S_DONE);
  assign rdata_o      = rdata_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: zero-wait instance on a RAM model plus a WAIT_CYCLES=3 instance.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we, sx;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, ram_addr, ram_datain, ram_dataout;
  logic        busy, done, misalign, ram_write, ram_read;

  logic        req2;
  logic [31:0] rdata2, ram_addr2, ram_datain2;
  logic        busy2, done2, misalign2, ram_write2, ram_read2;

  logic [31:0] mem [0:15];
  logic        pk_en = 1'b0;
  logic [3:0]  pk_idx = 4'd0;
  logic [31:0] pk_data = 32'd0;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.WAIT_CYCLES(0)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .sign_ext_i(sx), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
    .busy_o(busy), .done_o(done), .misalign_o(misalign), .ram_addr_o(ram_addr),
    .ram_datain_o(ram_datain), .ram_write_o(ram_write), .ram_read_o(ram_read),
    .ram_dataout_i(ram_dataout)
  );

  mem_access_unit #(.WAIT_CYCLES(3)) dut_w (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .we_i(1'b0), .size_i(2'b10),
    .sign_ext_i(1'b0), .addr_i(32'h0), .wdata_i(32'h0), .rdata_o(rdata2),
    .busy_o(busy2), .done_o(done2), .misalign_o(misalign2), .ram_addr_o(ram_addr2),
    .ram_datain_o(ram_datain2), .ram_write_o(ram_write2), .ram_read_o(ram_read2),
    .ram_dataout_i(32'h0000_0055)
  );

  assign ram_dataout = mem[ram_addr[5:2]];

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr[5:2]] <= ram_datain;
    else if (pk_en) mem[pk_idx] <= pk_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_idx = idx; pk_data = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // Issue one request at cycle 0; report the cycle of done and which strobes appeared.
  task automatic access(input logic w, input logic [1:0] sz, input logic s,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int dcyc, output logic rd_seen, output logic wr_seen);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sx = s; addr = a; wdata = wd;
    dcyc = -1; rd_seen = 1'b0; wr_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (ram_read)  rd_seen = 1'b1;
      if (ram_write) wr_seen = 1'b1;
      if (done) begin
        dcyc = k;
        break;
      end
    end
  endtask

  int         dc;
  logic       rs, ws;
  logic [7:0] bz;
  int         dc2;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sx = 1'b0;
    addr = 32'h0; wdata = 32'h0; req2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_ram_rd_wr", {30'd0, ram_read, ram_write}, 32'd0);

    poke(4'd1, 32'h0000_0003);
    poke(4'd2, 32'h1122_3344);
    poke(4'd0, 32'h0000_0002);

    access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, dc, rs, ws);
    check("lw_done_cyc", dc, 32'd2);
    check("lw_rdata", rdata, 32'h0000_0003);
    check("lw_no_write", {31'd0, ws}, 32'd0);
    check("lw_read_seen", {31'd0, rs}, 32'd1);

    access(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00A5, dc, rs, ws);
    check("sb_done_cyc", dc, 32'd3);
    check("sb_mem", mem[2], 32'h1122_A544);
    check("sb_rdata_hold", rdata, 32'h0000_0003);

    access(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, dc, rs, ws);
    check("lb_done_cyc", dc, 32'd2);
    check("lb_rdata", rdata, 32'hFFFF_FFA5);
    access(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, dc, rs, ws);
    check("lbu_rdata", rdata, 32'h0000_00A5);
    access(1'b0, 2'b00, 1'b1, 32'h8, 32'h0, dc, rs, ws);
    check("lb_pos_rdata", rdata, 32'h0000_0044);

    access(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, dc, rs, ws);
    check("sh_done_cyc", dc, 32'd3);
    check("sh_mem", mem[1], 32'hBEEF_0003);
    access(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, dc, rs, ws);
    check("lh_rdata", rdata, 32'hFFFF_BEEF);
    access(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, dc, rs, ws);
    check("lhu_rdata", rdata, 32'h0000_BEEF);

    access(1'b1, 2'b11, 1'b0, 32'hC, 32'hCAFE_F00D, dc, rs, ws);
    check("sw11_done_cyc", dc, 32'd2);
    check("sw11_mem", mem[3], 32'hCAFE_F00D);
    check("sw11_rdata_hold", rdata, 32'h0000_BEEF);
    access(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, dc, rs, ws);
    check("lw_c_rdata", rdata, 32'hCAFE_F00D);

    access(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, dc, rs, ws);
`ifdef MISALIGN_TRAP_EN
    check("mis_done_cyc", dc, 32'd1);
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_no_read", {31'd0, rs}, 32'd0);
    check("mis_rdata_hold", rdata, 32'hCAFE_F00D);
    @(negedge clk);
    check("mis_flag_held", {31'd0, misalign}, 32'd1);
`else
    check("mis_done_cyc", dc, 32'd2);
    check("mis_rdata", rdata, 32'h0000_0002);
    check("mis_flag", {31'd0, misalign}, 32'd0);
`endif
    access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, dc, rs, ws);
    check("mis_clear", {31'd0, misalign}, 32'd0);
    check("lw0_rdata", rdata, 32'h0000_0002);

    // Reset asserted while the sub-word store sits in WRITE.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sx = 1'b0; addr = 32'h8; wdata = 32'h77;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rstw_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_write_gated", {31'd0, ram_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_done", {31'd0, done}, 32'd0);
    check("rstw_rdata", rdata, 32'h0);
    check("rstw_mem", mem[2], 32'h1122_A544);
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, dc, rs, ws);
    check("rstw_idle_lw_cyc", dc, 32'd2);
    check("rstw_idle_lw", rdata, 32'h1122_A544);

    // WAIT_CYCLES=3 instance.
    @(negedge clk);
    req2 = 1'b1;
    bz = 8'd0; dc2 = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req2 = 1'b0;
      bz[k] = busy2;
      if (done2 && dc2 < 0) dc2 = k;
    end
    check("wait_busy_map", {24'd0, bz}, 32'h0000_001E);
    check("wait_done_cyc", dc2, 32'd5);
    check("wait_rdata", rdata2, 32'h0000_0055);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: WAIT_CYCLES, default 0, extra wait-state cycles (0..15) inserted before each RAM access.
REQ-002 Clock  in  1  single clock; all state updates on posedge.
REQ-003 Reset  in  1  synchronous, active-high.
REQ-004 req  in  1  CPU access request; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rdata  out  32  extended load result.
REQ-011 busy  out  1  high in WAIT, ACCESS and WRITE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 misalign  out  1  misaligned-access flag (see Configuration).
REQ-014 ram_addr  out  32  word address to the data RAM, {addr_q[31:2],2'b00}.
REQ-015 ram_datain  out  32  write data to the RAM.
REQ-016 ram_write  out  1  RAM write strobe; RAM commits on the posedge ending the cycle.
REQ-017 ram_read  out  1  RAM read enable.
REQ-018 ram_dataout  in  32  combinational RAM read data, valid in the same cycle as ram_read.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, ACCESS, WRITE and DONE.
REQ-020 IDLE: on req=1, the unit SHALL latch addr, wdata, size, we and sign_ext, then go to WAIT if WAIT_CYCLES>0, else to ACCESS.
REQ-021 WAIT SHALL load a counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to ACCESS when it reaches 0.
REQ-022 ACCESS SHALL assert ram_read for exactly one cycle.
REQ-023 ACCESS, load: the unit SHALL capture the selected lane of ram_dataout into rdata, extend it per sign_ext, and go to DONE.
REQ-024 ACCESS, word store: the unit SHALL assert ram_write with ram_datain=wdata_q and go to DONE.
REQ-025 ACCESS, sub-word store: the unit SHALL latch ram_dataout into a merge register and go to WRITE.
REQ-026 WRITE SHALL assert ram_write with ram_datain equal to the merge word, with only the target lane replaced, then go to DONE.
REQ-027 Lanes SHALL be little-endian: byte k = bits [8k+7:8k] with k=addr_q[1:0]; half h = bits [16h+15:16h] with h=addr_q[1].
REQ-028 DONE SHALL pulse done=1 for one cycle and return to IDLE; req is ignored in DONE and while busy.
REQ-029 Latency (WAIT_CYCLES=0), counted from the req cycle: load or word store SHALL pulse done at cycle 2; sub-word store at cycle 3; every path adds WAIT_CYCLES.
REQ-030 rdata SHALL change only when a load completes and SHALL hold its value otherwise, including across stores.
REQ-031 ram_read and ram_write SHALL be 0 in every other state.

Reset
REQ-032 Reset=1 SHALL force state to IDLE and clear rdata, busy, done, misalign, the counter and all latched registers to 0 on the next posedge.
REQ-033 ram_write and ram_read SHALL be gated to 0 combinationally while Reset=1, so reset mid-access never commits a RAM write.

Configuration
REQ-034 The macro MISALIGN_TRAP_EN SHALL control handling of misaligned accesses: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-035 With MISALIGN_TRAP_EN defined, a misaligned request SHALL go from IDLE directly to DONE with no RAM access.
REQ-036 In that case misalign SHALL be set with the done pulse and held until the next accepted req.
REQ-037 Without MISALIGN_TRAP_EN, the offending low address bits SHALL be ignored (aligned down) and misalign SHALL be tied to 0.

Verification
REQ-038 RAM word1=0x00000003, LW addr 0x4 issued at cycle 0 -> done at cycle 2, rdata=0x00000003, ram_write never asserted.
REQ-039 RAM word2=0x11223344, SB wdata=0xA5 addr 0x9 -> done at cycle 3, word2=0x1122A544; then LB sign_ext=1 addr 0x9 -> rdata=0xFFFFFFA5; LBU -> 0x000000A5.
REQ-040 RAM word1=0x00000003, SH wdata=0xBEEF addr 0x6 -> word1=0xBEEF0003; LH sign_ext=1 addr 0x6 -> rdata=0xFFFFBEEF.
REQ-041 WAIT_CYCLES=3, LW addr 0x0 -> busy high for cycles 1-4, done at cycle 5.
REQ-042 SB in progress, Reset=1 during the WRITE cycle -> ram_write stays 0, RAM word unchanged, busy=0 and state IDLE on the next cycle.
REQ-043 LW addr 0x2 with RAM word0=0x00000002: with MISALIGN_TRAP_EN -> done at cycle 1, misalign=1, no ram_read; without it -> rdata=0x00000002, misalign=0.
